// File: rtl/fetch_stage_pkg.sv
// Shared state encodings and constants for the instruction-fetch stage.
`ifndef FETCH_STAGE_PKG_SV
`define FETCH_STAGE_PKG_SV
package fetch_stage_pkg;

   localparam int unsigned FS_PC_INC = 4;
   localparam logic [31:0] FS_NOP    = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_IDLE    = 2'd0,
      FS_FETCH   = 2'd1,
      FS_HOLD    = 2'd2,
      FS_DISCARD = 2'd3
   } fs_state_e;

endpackage
`endif

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register; catches a response that arrives while decode is stalled.
module fetch_skid_buffer #(
   parameter int unsigned IWIDTH   = 32,
   parameter int unsigned PC_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_i,
   input  logic                drain_i,
   input  logic                clear_i,
   input  logic [IWIDTH-1:0]   instr_i,
   input  logic [PC_WIDTH-1:0] pc_i,
   output logic                valid_o,
   output logic [IWIDTH-1:0]   instr_o,
   output logic [PC_WIDTH-1:0] pc_o
);

   logic                valid_q;
   logic [IWIDTH-1:0]   instr_q;
   logic [PC_WIDTH-1:0] pc_q;

   // Clear (flush) beats load, load beats drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         instr_q <= instr_i;
         pc_q    <= pc_i;
      end else if (drain_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding hold-until-ack memory master, stall/flush handling.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect emits a NOP flagged fs_o_misaligned and halts.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned          PC_WIDTH = 32,
   parameter int unsigned          IWIDTH   = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
   parameter int unsigned          PC_INC   = FS_PC_INC
) (
   input  logic                fs_clk,
   input  logic                fs_rst,
   input  logic                fs_i_stall,
   input  logic                fs_i_flush,
   input  logic [PC_WIDTH-1:0] fs_i_pc_target,
   output logic [PC_WIDTH-1:0] fs_o_iaddr,
   output logic                fs_o_stb,
   input  logic                fs_i_ack,
   input  logic [IWIDTH-1:0]   fs_i_inst,
   output logic [IWIDTH-1:0]   fs_o_instr,
   output logic [PC_WIDTH-1:0] fs_o_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic                fs_o_misaligned,
`endif
   output logic                fs_o_ce
);

   fs_state_e           state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d, iaddr_q, iaddr_d, out_pc_q, out_pc_d;
   logic [IWIDTH-1:0]   out_instr_q, out_instr_d;
   logic                stb_q, stb_d, out_ce_q, out_ce_d;
   logic                halt_q, halt_d, misal_q, misal_d;
   logic                ack_c, pending_c, misal_tgt_c;
   logic [PC_WIDTH-1:0] target_c;
   logic                skid_load_c, skid_drain_c, skid_clear_c, skid_valid;
   logic [IWIDTH-1:0]   skid_instr;
   logic [PC_WIDTH-1:0] skid_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign misal_tgt_c = |fs_i_pc_target[1:0];
   assign target_c    = fs_i_pc_target;
`else
   assign misal_tgt_c = 1'b0;
   assign target_c    = fs_i_pc_target & ~PC_WIDTH'(3);
`endif

   assign ack_c     = fs_i_ack & stb_q;
   // A request on the bus that is not completing this cycle must not be withdrawn.
   assign pending_c = stb_q & ~fs_i_ack;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      out_instr_d  = out_instr_q;
      out_pc_d     = out_pc_q;
      out_ce_d     = out_ce_q;
      halt_d       = halt_q;
      misal_d      = misal_q;
      skid_load_c  = 1'b0;
      skid_drain_c = 1'b0;
      skid_clear_c = 1'b0;
      if (!fs_i_stall) out_ce_d = 1'b0;
      if (fs_i_flush) begin
         pc_d         = target_c;
         out_ce_d     = 1'b0;
         skid_clear_c = 1'b1;
         halt_d       = 1'b0;
         state_d      = pending_c ? FS_DISCARD : FS_FETCH;
         if (misal_tgt_c) begin
            out_ce_d    = 1'b1;
            out_instr_d = IWIDTH'(FS_NOP);
            out_pc_d    = fs_i_pc_target;
            misal_d     = 1'b1;
            halt_d      = 1'b1;
            if (!pending_c) state_d = FS_HOLD;
         end
      end else begin
         unique case (state_q)
            FS_IDLE: state_d = FS_FETCH;
            FS_FETCH: begin
               if (ack_c) begin
                  pc_d = pc_q + PC_WIDTH'(PC_INC);
                  if (!out_ce_q || !fs_i_stall) begin
                     out_instr_d = fs_i_inst;
                     out_pc_d    = iaddr_q;
                     out_ce_d    = 1'b1;
                     misal_d     = 1'b0;
                  end else begin
                     skid_load_c = 1'b1;
                     state_d     = FS_HOLD;
                  end
               end
            end
            FS_HOLD: begin
               if (!halt_q && !fs_i_stall) begin
                  out_instr_d  = skid_instr;
                  out_pc_d     = skid_pc;
                  out_ce_d     = skid_valid;
                  misal_d      = 1'b0;
                  skid_drain_c = 1'b1;
                  state_d      = FS_FETCH;
               end
            end
            FS_DISCARD: begin
               if (ack_c) state_d = halt_q ? FS_HOLD : FS_FETCH;
            end
            default: state_d = FS_IDLE;
         endcase
      end
      misal_d = misal_d & out_ce_d;
   end

   // DISCARD keeps the stale address on the bus until its ack arrives.
   assign stb_d   = (state_d == FS_FETCH) || (state_d == FS_DISCARD);
   assign iaddr_d = (state_d == FS_DISCARD) ? iaddr_q : pc_d;

   always_ff @(posedge fs_clk) begin
      if (fs_rst) begin
         state_q     <= FS_IDLE;
         pc_q        <= RESET_PC;
         iaddr_q     <= RESET_PC;
         stb_q       <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
         out_ce_q    <= 1'b0;
         halt_q      <= 1'b0;
         misal_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         iaddr_q     <= iaddr_d;
         stb_q       <= stb_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         out_ce_q    <= out_ce_d;
         halt_q      <= halt_d;
         misal_q     <= misal_d;
      end
   end

   fetch_skid_buffer #(
      .IWIDTH   (IWIDTH),
      .PC_WIDTH (PC_WIDTH)
   ) u_skid (
      .clk     (fs_clk),
      .rst     (fs_rst),
      .load_i  (skid_load_c),
      .drain_i (skid_drain_c),
      .clear_i (skid_clear_c),
      .instr_i (fs_i_inst),
      .pc_i    (iaddr_q),
      .valid_o (skid_valid),
      .instr_o (skid_instr),
      .pc_o    (skid_pc)
   );

   assign fs_o_iaddr = iaddr_q;
   assign fs_o_stb   = stb_q;
   assign fs_o_instr = out_instr_q;
   assign fs_o_pc    = out_pc_q;
   assign fs_o_ce    = out_ce_q;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign fs_o_misaligned = misal_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory model returns the request address as data after lat wait cycles.
module tb_fetch_stage;

   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0;
   logic [31:0] target = '0;
   logic [31:0] iaddr, inst, instr, pc;
   logic        stb, ack, ce;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misal;
`endif
   int unsigned lat = 0, wcnt = 0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   assign ack  = stb && (wcnt >= lat);
   assign inst = iaddr;

   always @(posedge clk) begin
      if (rst || !stb || ack) wcnt <= 0;
      else                    wcnt <= wcnt + 1;
   end

   fetch_stage dut (
      .fs_clk         (clk),
      .fs_rst         (rst),
      .fs_i_stall     (stall),
      .fs_i_flush     (flush),
      .fs_i_pc_target (target),
      .fs_o_iaddr     (iaddr),
      .fs_o_stb       (stb),
      .fs_i_ack       (ack),
      .fs_i_inst      (inst),
      .fs_o_instr     (instr),
      .fs_o_pc        (pc),
`ifdef FETCH_MISALIGN_CHECK_EN
      .fs_o_misaligned(misal),
`endif
      .fs_o_ce        (ce)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; flush = 1'b0; stall = 1'b0;
      tick; tick;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset values, then zero-wait streaming
      lat = 0; do_reset();
      check("rst_stb", stb, 0); check("rst_iaddr", iaddr, 0); check("rst_ce", ce, 0);
      check("rst_instr", instr, 0); check("rst_pc", pc, 0);
      tick;
      check("s1_stb", stb, 1); check("s1_iaddr", iaddr, 0); check("s1_ce", ce, 0);
      for (int i = 0; i < 4; i++) begin
         tick;
         check("s1_ce_on", ce, 1); check("s1_pc", pc, 32'(4*i)); check("s1_instr", instr, 32'(4*i));
      end

      // 3-cycle ack latency: strobe/address held, one output per 4 cycles
      lat = 3; do_reset();
      for (int c = 0; c < 13; c++) begin
         tick;
         check("s2_stb", stb, 1);
         check("s2_iaddr", iaddr, 32'(4*(c/4)));
         check("s2_ce", ce, 32'((c >= 4) && (c % 4 == 0)));
         if ((c >= 4) && (c % 4 == 0)) check("s2_pc", pc, 32'(4*(c/4 - 1)));
      end

      // Stall with response landing in the skid buffer
      lat = 0; do_reset();
      repeat (6) tick;
      check("s3_pre_pc", pc, 32'h10); check("s3_pre_iaddr", iaddr, 32'h14);
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("s3_hold_ce", ce, 1); check("s3_hold_pc", pc, 32'h10);
         check("s3_hold_instr", instr, 32'h10); check("s3_hold_stb", stb, 0);
      end
      stall = 1'b0;
      tick;
      check("s3_skid_pc", pc, 32'h14); check("s3_skid_instr", instr, 32'h14);
      check("s3_skid_ce", ce, 1); check("s3_resume_iaddr", iaddr, 32'h18);
      tick;
      check("s3_next_pc", pc, 32'h18); check("s3_next_ce", ce, 1);

      // Flush while request to 0x20 is pending
      lat = 0; do_reset();
      repeat (9) tick;
      lat = 3;
      check("s4_pre_iaddr", iaddr, 32'h20); check("s4_pre_pc", pc, 32'h1C);
      flush = 1'b1; target = 32'h100;
      tick; flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("s4_disc_stb", stb, 1); check("s4_disc_iaddr", iaddr, 32'h20); check("s4_disc_ce", ce, 0);
         tick;
      end
      check("s4_tgt_iaddr", iaddr, 32'h100); check("s4_tgt_ce", ce, 0);
      lat = 0;
      tick;
      check("s4_tgt_out_ce", ce, 1); check("s4_tgt_out_pc", pc, 32'h100);

      // Flush, ack and stall in the same cycle
      lat = 0; do_reset();
      repeat (4) tick;
      stall = 1'b1; flush = 1'b1; target = 32'h40;
      tick; flush = 1'b0;
      check("s5_ce", ce, 0); check("s5_stb", stb, 1); check("s5_iaddr", iaddr, 32'h40);
      tick; stall = 1'b0;
      check("s5_out_ce", ce, 1); check("s5_out_pc", pc, 32'h40);
      tick;
      check("s5_next_pc", pc, 32'h44); check("s5_next_ce", ce, 1);

      // PC wrap at the top of the address space
      lat = 0; do_reset();
      repeat (2) tick;
`ifdef FETCH_MISALIGN_CHECK_EN
      target = 32'hFFFF_FFFC;
`else
      target = 32'hFFFF_FFFE;
`endif
      flush = 1'b1;
      tick; flush = 1'b0;
      check("s6_iaddr", iaddr, 32'hFFFF_FFFC); check("s6_ce", ce, 0);
      tick;
      check("s6_pc", pc, 32'hFFFF_FFFC); check("s6_wrap_iaddr", iaddr, 32'h0);
      tick;
      check("s6_wrap_pc", pc, 32'h0);

      // Reset in the middle of a pending request
      lat = 3; do_reset();
      repeat (3) tick;
      rst = 1'b1;
      tick;
      check("s7_stb", stb, 0); check("s7_ce", ce, 0); check("s7_iaddr", iaddr, 0);
      rst = 1'b0;

`ifdef FETCH_MISALIGN_CHECK_EN
      // Misaligned redirect: NOP with flag, then halt until the next flush
      lat = 0; do_reset();
      repeat (4) tick;
      flush = 1'b1; target = 32'h102;
      tick; flush = 1'b0;
      check("s8_stb", stb, 0); check("s8_ce", ce, 1); check("s8_instr", instr, 32'h13);
      check("s8_pc", pc, 32'h102); check("s8_misal", misal, 1);
      tick;
      check("s8_ce_off", ce, 0); check("s8_misal_off", misal, 0); check("s8_halt_stb", stb, 0);
      tick;
      check("s8_halt_stb2", stb, 0);
      flush = 1'b1; target = 32'h200;
      tick; flush = 1'b0;
      check("s8_res_stb", stb, 1); check("s8_res_iaddr", iaddr, 32'h200);
      tick;
      check("s8_res_ce", ce, 1); check("s8_res_pc", pc, 32'h200); check("s8_res_misal", misal, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
